// File: rtl/box_occupancy_detector.sv
// rtl/box_occupancy_detector.sv - per-cell foreground counting and debounced occupancy for the five-box grid
// Stage 1 decodes which box interior the pixel hits; stage 2 counts hits per cell and closes the frame.
module box_occupancy_detector #(
    parameter int BOX_TL_X  = 100,
    parameter int BOX_TL_Y  = 100,
    parameter int BOX_SIDE  = 80,
    parameter int NUM_CELLS = 5,
    parameter int CNT_W     = 13,
    parameter int THRESH    = 800,
    parameter int PERSIST   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [30:0]          hCounter_in,
    input  logic [30:0]          vCounter_in,
    input  logic                 pixel_valid_in,
    input  logic                 fg_in,
    input  logic                 frame_end_in,
    input  logic [2:0]           cell_sel_in,
    output logic [NUM_CELLS-1:0] occupied,
    output logic                 occ_valid,
    output logic [CNT_W-1:0]     cell_count
);

    localparam int               PITCH     = BOX_SIDE + 5;
    localparam logic [30:0]      Y_LO      = 31'(BOX_TL_Y);
    localparam logic [30:0]      Y_HI      = 31'(BOX_TL_Y + BOX_SIDE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [4:0]       PERSIST_C = 5'(PERSIST);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_CLOSE  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 row_in;
    logic [NUM_CELLS-1:0] in_cell;
    logic [NUM_CELLS-1:0] hit_d, hit_q;
    logic                 fe_q;

    logic                 close_en, update_en, occ_valid_d, occ_valid_q;

    logic [CNT_W-1:0]     acc_q     [NUM_CELLS];
    logic [CNT_W-1:0]     acc_d     [NUM_CELLS];
    logic [CNT_W-1:0]     latch_q   [NUM_CELLS];
    logic [CNT_W-1:0]     latch_d   [NUM_CELLS];
    logic [CNT_W-1:0]     frame_sum [NUM_CELLS];
    logic [NUM_CELLS-1:0] hot_q, hot_d;

    logic [3:0]           run_q     [NUM_CELLS];
    logic [3:0]           run_d     [NUM_CELLS];
    logic [4:0]           run_inc   [NUM_CELLS];
    logic [NUM_CELLS-1:0] occ_q, occ_d;

    logic [CNT_W-1:0]     count_sel, cell_count_q;

    // Interior decode; the 5-pixel border between cells matches no cell.
    always_comb begin
        in_cell = '0;
        row_in  = (vCounter_in >= Y_LO) && (vCounter_in < Y_HI);
        for (int k = 0; k < NUM_CELLS; k++) begin
            in_cell[k] = row_in
                && (hCounter_in >= 31'(BOX_TL_X + k * PITCH))
                && (hCounter_in <  31'(BOX_TL_X + k * PITCH + BOX_SIDE));
        end
        hit_d = in_cell & {NUM_CELLS{pixel_valid_in & fg_in}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            fe_q  <= 1'b0;
        end else begin
            hit_q <= hit_d;
            fe_q  <= frame_end_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:  if (fe_q) state_d = ST_CLOSE;
            ST_CLOSE:  state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_ACCUM;
            default:   state_d = ST_ACCUM;
        endcase
    end

    // A frame end seen outside ACCUM is dropped.
    always_comb begin
        close_en    = (state_q == ST_ACCUM) && fe_q;
        update_en   = (state_q == ST_CLOSE);
        occ_valid_d = update_en;
    end

    // frame_sum is both the next count and the closing total, so a hit
    // coincident with the close lands in the frame being latched.
    always_comb begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            frame_sum[k] = (hit_q[k] && (acc_q[k] != CNT_MAX)) ? acc_q[k] + CNT_W'(1) : acc_q[k];
            acc_d[k]     = close_en ? '0 : frame_sum[k];
            latch_d[k]   = close_en ? frame_sum[k] : latch_q[k];
            hot_d[k]     = close_en ? (frame_sum[k] >= THRESH_C) : hot_q[k];
        end
    end

    always_comb begin
        occ_d = occ_q;
        for (int k = 0; k < NUM_CELLS; k++) begin
            run_d[k]   = run_q[k];
            run_inc[k] = {1'b0, run_q[k]} + 5'd1;
            if (update_en) begin
                if (hot_q[k] == occ_q[k]) begin
                    run_d[k] = '0;
                end else if (run_inc[k] == PERSIST_C) begin
                    occ_d[k] = hot_q[k];
                    run_d[k] = '0;
                end else begin
                    run_d[k] = run_inc[k][3:0];
                end
            end
        end
    end

    always_comb begin
        count_sel = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (cell_sel_in == 3'(k)) count_sel = latch_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CELLS; k++) begin
                acc_q[k]   <= '0;
                latch_q[k] <= '0;
                run_q[k]   <= '0;
            end
            hot_q        <= '0;
            occ_q        <= '0;
            occ_valid_q  <= 1'b0;
            cell_count_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CELLS; k++) begin
                acc_q[k]   <= acc_d[k];
                latch_q[k] <= latch_d[k];
                run_q[k]   <= run_d[k];
            end
            hot_q        <= hot_d;
            occ_q        <= occ_d;
            occ_valid_q  <= occ_valid_d;
            cell_count_q <= count_sel;
        end
    end

    assign occupied   = occ_q;
    assign occ_valid  = occ_valid_q;
    assign cell_count = cell_count_q;

endmodule

// File: tb/tb_box_occupancy_detector.sv
// tb/tb_box_occupancy_detector.sv - directed and randomized checks of box_occupancy_detector against a frame-level model
`timescale 1ns/1ps
module tb_box_occupancy_detector;

    localparam int TLX = 100, TLY = 100, SIDE = 80, PITCH = SIDE + 5;
    localparam int NC = 5, CW = 13, THRESH = 800, PERSIST = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [30:0] h = '0, v = '0;
    logic        pv = 1'b0, fg = 1'b0, fe = 1'b0;
    logic [2:0]  sel = '0;
    logic [4:0]  occupied;
    logic        occ_valid;
    logic [12:0] cell_count;

    always #5 clk = ~clk;

    box_occupancy_detector #(
        .BOX_TL_X(TLX), .BOX_TL_Y(TLY), .BOX_SIDE(SIDE), .NUM_CELLS(NC),
        .CNT_W(CW), .THRESH(THRESH), .PERSIST(PERSIST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hCounter_in(h), .vCounter_in(v),
        .pixel_valid_in(pv), .fg_in(fg), .frame_end_in(fe),
        .cell_sel_in(sel),
        .occupied(occupied), .occ_valid(occ_valid), .cell_count(cell_count)
    );

    int total = 0, bad = 0;

    // Frame-level model: open-frame counts, closed-frame counts, streaks of disagreeing frames.
    int         cur[NC], lat_m[NC], lat_vis[NC], streak[NC];
    logic [4:0] occ_m = '0, occ_vis = '0;
    longint     slot = 0, last_fe = -100;

    function automatic int cell_of(longint hh, longint vv);
        longint dx;
        if (vv < TLY || vv >= TLY + SIDE || hh < TLX) return -1;
        dx = hh - TLX;
        if (dx / PITCH >= NC || dx % PITCH >= SIDE) return -1;
        return int'(dx / PITCH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            cur[k] = 0; lat_m[k] = 0; lat_vis[k] = 0; streak[k] = 0;
        end
        occ_m = '0; occ_vis = '0; last_fe = -100;
    endtask

    task automatic close_frame();
        for (int k = 0; k < NC; k++) begin
            logic hot;
            hot = (cur[k] >= THRESH);
            lat_m[k] = cur[k];
            cur[k] = 0;
            if (hot == occ_m[k]) streak[k] = 0;
            else begin
                streak[k]++;
                if (streak[k] == PERSIST) begin
                    occ_m[k] = hot;
                    streak[k] = 0;
                end
            end
        end
        last_fe = slot;
    endtask

    // One pixel slot: drive at negedge, let the posedge sample it, check at the next negedge.
    task automatic cyc(input longint hh, input longint vv, input logic pvv, input logic fgg,
                       input logic fee, input logic [2:0] s);
        int c;
        h = 31'(hh); v = 31'(vv); pv = pvv; fg = fgg; fe = fee; sel = s;
        c = cell_of(hh, vv);
        if (pvv && fgg && c >= 0) cur[c]++;
        if (fee && !(slot == last_fe + 1 || slot == last_fe + 2)) close_frame();
        @(negedge clk);
        if (slot == last_fe + 2) occ_vis = occ_m;
        chk("occ_valid", {31'd0, occ_valid}, {31'd0, slot == last_fe + 2});
        chk("occupied", {27'd0, occupied}, {27'd0, occ_vis});
        chk("cell_count", {19'd0, cell_count}, (int'(s) < NC) ? lat_vis[int'(s)] : 0);
        if (slot == last_fe + 1) lat_vis = lat_m;
        slot++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, 1'b0, 1'b0, 3'(i % 8));
    endtask

    task automatic fill(input int k, input int n, input logic fe_last);
        for (int i = 0; i < n; i++)
            cyc(TLX + k * PITCH + i % SIDE, TLY + i / SIDE, 1'b1, 1'b1, fe_last && (i == n - 1), 3'(slot % 8));
    endtask

    task automatic end_frame();
        cyc(0, 0, 1'b0, 1'b0, 1'b1, 3'd0);
        idle(3);
    endtask

    task automatic readback(input int k, input int exp, input string tag);
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 3'(k));
        chk(tag, {19'd0, cell_count}, exp);
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_occupied", {27'd0, occupied}, 0);
        chk("reset_occ_valid", {31'd0, occ_valid}, 0);
        chk("reset_cell_count", {19'd0, cell_count}, 0);
        rst_n = 1'b1;

        // Cell 2 fully lit for three frames.
        for (int f = 0; f < 3; f++) begin
            fill(2, SIDE * SIDE, 1'b1);
            idle(3);
            chk("A_occupied", {27'd0, occupied}, (f == 2) ? 32'h04 : 32'h00);
        end
        readback(2, 6400, "A_count2");

        // Border-only foreground.
        for (int vv = TLY; vv < TLY + SIDE; vv++)
            for (int hh = 180; hh < 185; hh++) cyc(hh, vv, 1'b1, 1'b1, 1'b0, 3'(slot % 8));
        for (int hh = 100; hh <= 520; hh++) cyc(hh, 99, 1'b1, 1'b1, 1'b0, 3'(slot % 8));
        end_frame();
        for (int k = 0; k < 8; k++) readback(k, 0, "B_border_count");

        // Threshold edge in cell 0.
        for (int f = 0; f < 3; f++) begin
            fill(0, THRESH - 1, 1'b1); idle(3);
            chk("C_799_bit0", {31'd0, occupied[0]}, 0);
        end
        for (int f = 0; f < 3; f++) begin
            fill(0, THRESH, 1'b1); idle(3);
            chk("C_800_bit0", {31'd0, occupied[0]}, (f == 2) ? 1 : 0);
        end
        readback(0, 800, "C_count0");

        // Cell 4 alternating hot/cold never flips.
        for (int f = 0; f < 4; f++) begin
            if (f % 2 == 0) fill(4, THRESH, 1'b1); else cyc(0, 0, 1'b0, 1'b0, 1'b1, 3'd0);
            if (f % 2 == 0) idle(3); else idle(3);
            chk("D_alt_bit4", {31'd0, occupied[4]}, 0);
        end
        for (int f = 0; f < 3; f++) begin
            fill(0, THRESH, 1'b0); fill(4, THRESH, 1'b1); idle(3);
            chk("D_both_hot", {27'd0, occupied}, (f == 2) ? 32'h11 : 32'h00);
        end
        for (int f = 0; f < 3; f++) begin
            fill(0, THRESH, 1'b1); idle(3);
            chk("D_cell4_cold", {27'd0, occupied}, (f == 2) ? 32'h01 : 32'h11);
        end
        for (int f = 0; f < 3; f++) begin
            fill(0, THRESH, 1'b0); fill(4, THRESH, 1'b1); idle(3);
            chk("D_rehot", {27'd0, occupied}, (f == 2) ? 32'h11 : 32'h01);
        end

        // Asynchronous reset mid-frame.
        fill(1, 200, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("R_async_occupied", {27'd0, occupied}, 0);
        chk("R_async_occ_valid", {31'd0, occ_valid}, 0);
        chk("R_async_cell_count", {19'd0, cell_count}, 0);
        pv = 1'b0; fg = 1'b0; fe = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fill(1, 50, 1'b1); idle(3);
        readback(1, 50, "R_count1");
        chk("R_occupied", {27'd0, occupied}, 0);

        // Pixel coincident with frame end, then an empty frame.
        fill(1, 101, 1'b1); idle(3);
        readback(1, 101, "E_incl");
        end_frame();
        readback(1, 0, "E_next_zero");

        // Pixels during CLOSE/UPDATE go to the new frame; a frame end during CLOSE is ignored.
        fill(3, 100, 1'b1);
        cyc(TLX + 3 * PITCH, TLY + 5, 1'b1, 1'b1, 1'b1, 3'd3);
        cyc(TLX + 3 * PITCH + 1, TLY + 5, 1'b1, 1'b1, 1'b0, 3'd3);
        idle(1);
        readback(3, 100, "E_close_count");
        end_frame();
        readback(3, 2, "E_carry_count");

        // Randomized frames near and across the grid.
        for (int f = 0; f < 15; f++) begin
            int n;
            n = $urandom_range(100, 400);
            for (int i = 0; i < n; i++) begin
                longint hh, vv;
                hh = ($urandom_range(0, 15) == 0) ? (longint'($urandom) & 64'h7FFF_FFFF) : longint'($urandom_range(90, 540));
                vv = ($urandom_range(0, 15) == 0) ? (longint'($urandom) & 64'h7FFF_FFFF) : longint'($urandom_range(90, 190));
                cyc(hh, vv, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                    (i == n - 1) || ($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 2) == 0) cyc(TLX, TLY, 1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)));
            for (int i = 0; i < 3; i++)
                cyc($urandom_range(90, 540), $urandom_range(90, 190), 1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
        end
        end_frame();
        for (int k = 0; k < 8; k++) cyc(0, 0, 1'b0, 1'b0, 1'b0, 3'(k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
